// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-port memory arbiter.
package mem_arb_pkg;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  localparam logic PORT_FETCH = 1'b0;
  localparam logic PORT_DATA  = 1'b1;
  localparam int   LAT_W      = 3;
endpackage

// File: rtl/mem_arbiter_if.sv
// Requester and memory-side bus of the arbiter; slave = arbiter view, master = requesters/memory view.
interface mem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              f_req;
  logic [ADDR_W-1:0] f_addr;
  logic              f_gnt;
  logic              f_rvalid;
  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic              d_gnt;
  logic              d_rvalid;
  logic [DATA_W-1:0] rdata;
  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  f_req, f_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    output f_gnt, f_rvalid, d_gnt, d_rvalid, rdata,
           mem_en, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output f_req, f_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    input  f_gnt, f_rvalid, d_gnt, d_rvalid, rdata,
           mem_en, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/rr_arb2.sv
// Two-way round-robin pick: a lone requester wins, a tie goes to the port not granted last.
module rr_arb2
  import mem_arb_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic       winner,
  output logic       valid
);
  always_comb begin
    winner = PORT_FETCH;
    if (&req)       winner = ~last_grant;
    else if (req[1]) winner = PORT_DATA;
  end

  assign valid = |req;
endmodule

// File: rtl/mem_arbiter.sv
// Shares one single-port synchronous memory between fetch (port 0) and data (port 1),
// one access in flight, fixed read latency MEM_LAT, all outputs registered.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int MEM_LAT = 1
) (
  input  logic          clk,
  input  logic          reset_n,
  mem_arbiter_if.slave  bus
);
  localparam bit              LAT1     = (MEM_LAT == 1);
  localparam logic [LAT_W-1:0] CNT_LAST = LAT_W'(MEM_LAT - 1);

  state_t            state;
  logic [LAT_W-1:0]  cnt;
  logic              win;
  logic              last_grant;
  logic              lat_we;
  logic              pick;
  logic              pick_vld;
  logic              done;

  rr_arb2 u_rr (
    .req        ({bus.d_req, bus.f_req}),
    .last_grant (last_grant),
    .winner     (pick),
    .valid      (pick_vld)
  );

  // With MEM_LAT = 1 the ISSUE edge is itself the capture edge (WAIT takes zero cycles).
  assign done = (state == ISSUE && LAT1) || (state == WAIT && cnt == CNT_LAST);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= IDLE;
      cnt           <= '0;
      win           <= PORT_FETCH;
      last_grant    <= PORT_DATA;
      lat_we        <= 1'b0;
      bus.f_gnt     <= 1'b0;
      bus.d_gnt     <= 1'b0;
      bus.f_rvalid  <= 1'b0;
      bus.d_rvalid  <= 1'b0;
      bus.rdata     <= {DATA_W{1'b0}};
      bus.mem_en    <= 1'b0;
      bus.mem_we    <= 1'b0;
      bus.mem_addr  <= {ADDR_W{1'b0}};
      bus.mem_wdata <= {DATA_W{1'b0}};
    end else begin
      case (state)
        IDLE: begin
          if (pick_vld) begin
            win           <= pick;
            last_grant    <= pick;
            lat_we        <= (pick == PORT_DATA) && bus.d_we;
            bus.f_gnt     <= (pick == PORT_FETCH);
            bus.d_gnt     <= (pick == PORT_DATA);
            bus.mem_en    <= 1'b1;
            bus.mem_we    <= (pick == PORT_DATA) && bus.d_we;
            bus.mem_addr  <= (pick == PORT_DATA) ? bus.d_addr : bus.f_addr;
            bus.mem_wdata <= (pick == PORT_DATA) ? bus.d_wdata : {DATA_W{1'b0}};
            state         <= ISSUE;
          end
        end
        ISSUE: begin
          bus.f_gnt  <= 1'b0;
          bus.d_gnt  <= 1'b0;
          bus.mem_en <= 1'b0;
          bus.mem_we <= 1'b0;
          cnt        <= LAT_W'(1);
          state      <= WAIT;
        end
        WAIT: cnt <= cnt + LAT_W'(1);
        RESP: begin
          bus.f_rvalid <= 1'b0;
          bus.d_rvalid <= 1'b0;
          state        <= IDLE;
        end
        default: state <= IDLE;
      endcase

      // Capture edge overrides the ISSUE/WAIT bookkeeping above.
      if (done) begin
        if (!lat_we) bus.rdata <= bus.mem_rdata;
        bus.f_rvalid <= (win == PORT_FETCH);
        bus.d_rvalid <= (win == PORT_DATA);
        cnt          <= '0;
        state        <= RESP;
      end
    end
  end
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: one instance at MEM_LAT=1, one at MEM_LAT=3, sharing clock/reset.
module tb_mem_arbiter;
  logic clk;
  logic reset_n;
  int   n_chk  = 0;
  int   n_pass = 0;

  mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus1 ();
  mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus3 ();

  mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(1)) u_dut1 (
    .clk(clk), .reset_n(reset_n), .bus(bus1)
  );
  mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(3)) u_dut3 (
    .clk(clk), .reset_n(reset_n), .bus(bus3)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  task automatic test_reset();
    @(negedge clk);
    if ({bus1.f_gnt, bus1.d_gnt, bus1.f_rvalid, bus1.d_rvalid, bus1.mem_en, bus1.mem_we,
         bus1.rdata, bus1.mem_addr, bus1.mem_wdata} !== '0) begin
      $display("FAIL reset_outs_lat1 got rdata=%h addr=%h wdata=%h want all 0",
               bus1.rdata, bus1.mem_addr, bus1.mem_wdata);
    end else n_pass++;
    n_chk++;
    if ({bus3.f_gnt, bus3.d_gnt, bus3.f_rvalid, bus3.d_rvalid, bus3.mem_en, bus3.mem_we,
         bus3.rdata, bus3.mem_addr, bus3.mem_wdata} !== '0) begin
      $display("FAIL reset_outs_lat3 got rdata=%h addr=%h wdata=%h want all 0",
               bus3.rdata, bus3.mem_addr, bus3.mem_wdata);
    end else n_pass++;
    n_chk++;
  endtask

  task automatic test_fetch();
    bus1.f_req = 1'b1; bus1.f_addr = 32'h10; bus1.mem_rdata = 32'hDEADBEEF;
    @(negedge clk);
    if ({bus1.f_gnt, bus1.d_gnt, bus1.mem_en, bus1.mem_we, bus1.f_rvalid} !== 5'b10100) begin
      $display("FAIL fetch_issue got gnt/dgnt/en/we/rv=%b want 10100",
               {bus1.f_gnt, bus1.d_gnt, bus1.mem_en, bus1.mem_we, bus1.f_rvalid});
    end else n_pass++;
    n_chk++;
    if (bus1.mem_addr !== 32'h10) begin
      $display("FAIL fetch_addr got %h want 00000010", bus1.mem_addr);
    end else n_pass++;
    n_chk++;
    @(negedge clk);
    if ({bus1.f_rvalid, bus1.d_rvalid, bus1.f_gnt, bus1.mem_en} !== 4'b1000) begin
      $display("FAIL fetch_rvalid got rv/drv/gnt/en=%b want 1000",
               {bus1.f_rvalid, bus1.d_rvalid, bus1.f_gnt, bus1.mem_en});
    end else n_pass++;
    n_chk++;
    if (bus1.rdata !== 32'hDEADBEEF) begin
      $display("FAIL fetch_rdata got %h want deadbeef", bus1.rdata);
    end else n_pass++;
    n_chk++;
    bus1.f_req = 1'b0;
    @(negedge clk);
    if ({bus1.f_rvalid, bus1.f_gnt, bus1.mem_en} !== 3'b000) begin
      $display("FAIL fetch_idle got rv/gnt/en=%b want 000",
               {bus1.f_rvalid, bus1.f_gnt, bus1.mem_en});
    end else n_pass++;
    n_chk++;
  endtask

  task automatic test_store();
    bus1.d_req = 1'b1; bus1.d_we = 1'b1; bus1.d_addr = 32'h40;
    bus1.d_wdata = 32'h12345678; bus1.mem_rdata = 32'hCAFEF00D;
    @(negedge clk);
    if ({bus1.d_gnt, bus1.f_gnt, bus1.mem_en, bus1.mem_we} !== 4'b1011 ||
        bus1.mem_addr !== 32'h40 || bus1.mem_wdata !== 32'h12345678) begin
      $display("FAIL store_issue got gnt/fgnt/en/we=%b addr=%h wdata=%h want 1011 00000040 12345678",
               {bus1.d_gnt, bus1.f_gnt, bus1.mem_en, bus1.mem_we}, bus1.mem_addr, bus1.mem_wdata);
    end else n_pass++;
    n_chk++;
    @(negedge clk);
    if ({bus1.d_rvalid, bus1.f_rvalid, bus1.mem_en, bus1.mem_we} !== 4'b1000) begin
      $display("FAIL store_rvalid got drv/frv/en/we=%b want 1000",
               {bus1.d_rvalid, bus1.f_rvalid, bus1.mem_en, bus1.mem_we});
    end else n_pass++;
    n_chk++;
    if (bus1.rdata !== 32'hDEADBEEF) begin
      $display("FAIL store_rdata_kept got %h want deadbeef", bus1.rdata);
    end else n_pass++;
    n_chk++;
    bus1.d_req = 1'b0; bus1.d_we = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_late_drop();
    int extra = 0;
    bus1.d_req = 1'b1; bus1.d_we = 1'b0; bus1.d_addr = 32'h44; bus1.mem_rdata = 32'h5A5A0044;
    @(negedge clk);
    if (bus1.d_gnt !== 1'b1) begin
      $display("FAIL drop_gnt got %b want 1", bus1.d_gnt);
    end else n_pass++;
    n_chk++;
    bus1.d_req = 1'b0;
    @(negedge clk);
    if (bus1.d_rvalid !== 1'b1 || bus1.rdata !== 32'h5A5A0044) begin
      $display("FAIL drop_rvalid got rv=%b rdata=%h want 1 5a5a0044", bus1.d_rvalid, bus1.rdata);
    end else n_pass++;
    n_chk++;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (bus1.d_gnt || bus1.f_gnt || bus1.mem_en || bus1.d_rvalid || bus1.f_rvalid) extra++;
    end
    if (extra !== 0) begin
      $display("FAIL drop_quiet got %0d active cycles want 0", extra);
    end else n_pass++;
    n_chk++;
  endtask

  task automatic test_back_to_back();
    logic       fe;
    logic [31:0] exp_addr;
    reset_n = 1'b0;
    #1 reset_n = 1'b1;
    bus1.f_req = 1'b1; bus1.f_addr = 32'h100;
    bus1.d_req = 1'b1; bus1.d_we = 1'b0; bus1.d_addr = 32'h200;
    for (int k = 0; k < 4; k++) begin
      fe = (k % 2 == 0);
      exp_addr = fe ? 32'h100 : 32'h200;
      @(negedge clk);
      bus1.mem_rdata = 32'hA0000000 + k;
      if ({bus1.f_gnt, bus1.d_gnt} !== {fe, ~fe} || bus1.mem_addr !== exp_addr) begin
        $display("FAIL b2b_gnt[%0d] got f/d=%b addr=%h want %b %h",
                 k, {bus1.f_gnt, bus1.d_gnt}, bus1.mem_addr, {fe, ~fe}, exp_addr);
      end else n_pass++;
      n_chk++;
      @(negedge clk);
      if ({bus1.f_rvalid, bus1.d_rvalid} !== {fe, ~fe} || bus1.rdata !== 32'hA0000000 + k) begin
        $display("FAIL b2b_rvalid[%0d] got f/d=%b rdata=%h want %b %h",
                 k, {bus1.f_rvalid, bus1.d_rvalid}, bus1.rdata, {fe, ~fe}, 32'hA0000000 + k);
      end else n_pass++;
      n_chk++;
      if (k == 3) begin bus1.f_req = 1'b0; bus1.d_req = 1'b0; end
      @(negedge clk);
      if ({bus1.f_gnt, bus1.d_gnt, bus1.f_rvalid, bus1.d_rvalid} !== 4'b0000) begin
        $display("FAIL b2b_idle[%0d] got %b want 0000",
                 k, {bus1.f_gnt, bus1.d_gnt, bus1.f_rvalid, bus1.d_rvalid});
      end else n_pass++;
      n_chk++;
    end
  endtask

  task automatic test_lat3();
    logic [3:0] rv_seen;
    bus3.d_req = 1'b1; bus3.d_we = 1'b0; bus3.d_addr = 32'h80; bus3.mem_rdata = 32'h11111111;
    @(negedge clk);
    if ({bus3.d_gnt, bus3.mem_en, bus3.mem_we} !== 3'b110 || bus3.mem_addr !== 32'h80) begin
      $display("FAIL lat3_issue got gnt/en/we=%b addr=%h want 110 00000080",
               {bus3.d_gnt, bus3.mem_en, bus3.mem_we}, bus3.mem_addr);
    end else n_pass++;
    n_chk++;
    rv_seen[1] = bus3.d_rvalid;
    @(negedge clk);
    rv_seen[2] = bus3.d_rvalid;
    bus3.mem_rdata = 32'h22222222;
    @(negedge clk);
    rv_seen[3] = bus3.d_rvalid;
    bus3.mem_rdata = 32'h33333333;
    @(negedge clk);
    rv_seen[0] = bus3.d_rvalid;
    if (rv_seen !== 4'b0001) begin
      $display("FAIL lat3_timing got rv cyc3..1,4=%b want 0001", rv_seen);
    end else n_pass++;
    n_chk++;
    if (bus3.rdata !== 32'h33333333) begin
      $display("FAIL lat3_rdata got %h want 33333333", bus3.rdata);
    end else n_pass++;
    n_chk++;
    bus3.d_req = 1'b0;
    bus3.mem_rdata = 32'h44444444;
    @(negedge clk);
    if (bus3.d_rvalid !== 1'b0 || bus3.rdata !== 32'h33333333) begin
      $display("FAIL lat3_after got rv=%b rdata=%h want 0 33333333", bus3.d_rvalid, bus3.rdata);
    end else n_pass++;
    n_chk++;
  endtask

  task automatic test_reset_mid();
    int rv_cnt = 0;
    bus3.f_req = 1'b1; bus3.f_addr = 32'h20; bus3.mem_rdata = 32'h77777777;
    @(negedge clk);
    if (bus3.f_gnt !== 1'b1) begin
      $display("FAIL rstmid_gnt got %b want 1", bus3.f_gnt);
    end else n_pass++;
    n_chk++;
    @(negedge clk);
    reset_n = 1'b0;
    bus3.f_req = 1'b0;
    #1;
    if ({bus3.f_gnt, bus3.d_gnt, bus3.f_rvalid, bus3.d_rvalid, bus3.mem_en, bus3.mem_we,
         bus3.rdata, bus3.mem_addr, bus3.mem_wdata} !== '0) begin
      $display("FAIL rstmid_outs got addr=%h rdata=%h want all 0", bus3.mem_addr, bus3.rdata);
    end else n_pass++;
    n_chk++;
    @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (bus3.f_rvalid || bus3.d_rvalid || bus3.f_gnt || bus3.mem_en) rv_cnt++;
    end
    if (rv_cnt !== 0) begin
      $display("FAIL rstmid_quiet got %0d active cycles want 0", rv_cnt);
    end else n_pass++;
    n_chk++;
  endtask

  initial begin
    reset_n = 1'b1;
    bus1.f_req = 1'b0; bus1.f_addr = '0; bus1.d_req = 1'b0; bus1.d_we = 1'b0;
    bus1.d_addr = '0; bus1.d_wdata = '0; bus1.mem_rdata = '0;
    bus3.f_req = 1'b0; bus3.f_addr = '0; bus3.d_req = 1'b0; bus3.d_we = 1'b0;
    bus3.d_addr = '0; bus3.d_wdata = '0; bus3.mem_rdata = '0;
    #1 reset_n = 1'b0;
    #3 reset_n = 1'b1;
    test_reset();
    test_fetch();
    test_store();
    test_late_drop();
    test_back_to_back();
    test_lat3();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
